// File: rtl/cv32e40x_rvfi_trace_sequencer.sv
// RVFI trace sequencer: buffers retired-instruction records and emits one beat per active memory slot.
// Optional feature macro: CV32E40X_RVFI_TRACE_SEQ_DROPCNT_EN (16-bit saturating drop counter).

package cv32e40x_rvfi_pkg;
  localparam int NMEM = 2;
endpackage

module cv32e40x_rvfi_trace_sequencer #(
  parameter int DEPTH = 4,
  parameter int NMEM = cv32e40x_rvfi_pkg::NMEM,
  localparam int SLOT_W = (NMEM > 1) ? $clog2(NMEM) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rvfi_valid,
  input  logic [31:0]          rvfi_pc_rdata,
  input  logic [4:0]           rvfi_rd_addr,
  input  logic [31:0]          rvfi_rd_wdata,
  input  logic [32*NMEM-1:0]   rvfi_mem_addr,
  input  logic [32*NMEM-1:0]   rvfi_mem_rdata,
  input  logic [32*NMEM-1:0]   rvfi_mem_wdata,
  input  logic [4*NMEM-1:0]    rvfi_mem_rmask,
  input  logic [4*NMEM-1:0]    rvfi_mem_wmask,
  output logic                 trace_valid_o,
  input  logic                 trace_ready_i,
  output logic [31:0]          trace_pc_o,
  output logic [4:0]           trace_rd_addr_o,
  output logic [31:0]          trace_rd_wdata_o,
  output logic [SLOT_W-1:0]    trace_slot_o,
  output logic [31:0]          trace_mem_addr_o,
  output logic [31:0]          trace_mem_rdata_o,
  output logic [31:0]          trace_mem_wdata_o,
  output logic [3:0]           trace_mem_rmask_o,
  output logic [3:0]           trace_mem_wmask_o,
  output logic                 trace_last_o,
  output logic                 overflow_o,
  output logic [15:0]          drop_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Record storage
  logic [31:0]        pc_mem_r     [DEPTH];
  logic [4:0]         rd_addr_mem_r[DEPTH];
  logic [31:0]        rd_wdata_mem_r[DEPTH];
  logic [32*NMEM-1:0] maddr_mem_r  [DEPTH];
  logic [32*NMEM-1:0] mrdata_mem_r [DEPTH];
  logic [32*NMEM-1:0] mwdata_mem_r [DEPTH];
  logic [4*NMEM-1:0]  rmask_mem_r  [DEPTH];
  logic [4*NMEM-1:0]  wmask_mem_r  [DEPTH];

  logic [PTR_W-1:0]   wptr_r;
  logic [PTR_W-1:0]   rptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [SLOT_W-1:0]  slot_r;
  state_e             state_r;
  state_e             state_s;

  logic               full_s;
  logic               push_s;
  logic               drop_s;
  logic               accept_s;
  logic               pop_s;

  logic [4*NMEM-1:0]  head_rmask_s;
  logic [4*NMEM-1:0]  head_wmask_s;
  logic [32*NMEM-1:0] head_maddr_s;
  logic [32*NMEM-1:0] head_mrdata_s;
  logic [32*NMEM-1:0] head_mwdata_s;
  logic [NMEM-1:0]    act_s;
  logic [SLOT_W-1:0]  cur_s;
  logic               cur_act_s;
  logic               more_s;
  logic               last_s;
  logic [31:0]        sel_addr_s;
  logic [31:0]        sel_rdata_s;
  logic [31:0]        sel_wdata_s;
  logic [3:0]         sel_rmask_s;
  logic [3:0]         sel_wmask_s;

  // Full is judged on registered occupancy, so a same-cycle pop never frees a slot for a push
  assign full_s   = (cnt_r == CNT_W'(DEPTH));
  assign push_s   = rvfi_valid & ~full_s;
  assign drop_s   = rvfi_valid & full_s;
  assign accept_s = (state_r == EMIT) & trace_ready_i;
  assign pop_s    = accept_s & last_s;

  assign head_rmask_s  = rmask_mem_r[rptr_r];
  assign head_wmask_s  = wmask_mem_r[rptr_r];
  assign head_maddr_s  = maddr_mem_r[rptr_r];
  assign head_mrdata_s = mrdata_mem_r[rptr_r];
  assign head_mwdata_s = mwdata_mem_r[rptr_r];

  // Record storage write port
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      pc_mem_r[wptr_r]       <= rvfi_pc_rdata;
      rd_addr_mem_r[wptr_r]  <= rvfi_rd_addr;
      rd_wdata_mem_r[wptr_r] <= rvfi_rd_wdata;
      maddr_mem_r[wptr_r]    <= rvfi_mem_addr;
      mrdata_mem_r[wptr_r]   <= rvfi_mem_rdata;
      mwdata_mem_r[wptr_r]   <= rvfi_mem_wdata;
      rmask_mem_r[wptr_r]    <= rvfi_mem_rmask;
      wmask_mem_r[wptr_r]    <= rvfi_mem_wmask;
    end
  end

  // Next occupancy from push/pop
  always_comb begin
    cnt_next_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_next_s = cnt_r + CNT_W'(1'b1);
      2'b01:   cnt_next_s = cnt_r - CNT_W'(1'b1);
      default: cnt_next_s = cnt_r;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_r <= {PTR_W{1'b0}};
      rptr_r <= {PTR_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      wptr_r <= push_s ? (wptr_r + PTR_W'(1'b1)) : wptr_r;
      rptr_r <= pop_s ? (rptr_r + PTR_W'(1'b1)) : rptr_r;
      cnt_r  <= cnt_next_s;
    end
  end

  // Slot search: lowest active slot at or above slot_r, and whether one exists beyond it
  always_comb begin
    act_s  = {NMEM{1'b0}};
    cur_s  = {SLOT_W{1'b0}};
    more_s = 1'b0;
    for (int i = 0; i < NMEM; i++) begin
      act_s[i] = |(head_rmask_s[4*i +: 4] | head_wmask_s[4*i +: 4]);
    end
    for (int i = NMEM - 1; i >= 0; i--) begin
      cur_s = (act_s[i] && (i >= int'(slot_r))) ? SLOT_W'(i) : cur_s;
    end
    for (int i = 0; i < NMEM; i++) begin
      more_s = more_s | (act_s[i] && (i > int'(cur_s)));
    end
    cur_act_s = act_s[cur_s];
    last_s    = ~more_s;
  end

  // Per-slot field mux for the current slot
  always_comb begin
    sel_addr_s  = 32'h0;
    sel_rdata_s = 32'h0;
    sel_wdata_s = 32'h0;
    sel_rmask_s = 4'h0;
    sel_wmask_s = 4'h0;
    for (int i = 0; i < NMEM; i++) begin
      sel_addr_s  = (int'(cur_s) == i) ? head_maddr_s[32*i +: 32]  : sel_addr_s;
      sel_rdata_s = (int'(cur_s) == i) ? head_mrdata_s[32*i +: 32] : sel_rdata_s;
      sel_wdata_s = (int'(cur_s) == i) ? head_mwdata_s[32*i +: 32] : sel_wdata_s;
      sel_rmask_s = (int'(cur_s) == i) ? head_rmask_s[4*i +: 4]    : sel_rmask_s;
      sel_wmask_s = (int'(cur_s) == i) ? head_wmask_s[4*i +: 4]    : sel_wmask_s;
    end
  end

  // Slot pointer: advance past the accepted slot, restart at 0 for the next record
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_r <= {SLOT_W{1'b0}};
    end else if (pop_s) begin
      slot_r <= {SLOT_W{1'b0}};
    end else if (accept_s) begin
      slot_r <= cur_s + SLOT_W'(1'b1);
    end else begin
      slot_r <= slot_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = push_s ? EMIT : IDLE;
      EMIT:    state_s = (pop_s && (cnt_next_s == {CNT_W{1'b0}})) ? IDLE : EMIT;
      default: state_s = IDLE;
    endcase
  end

  // Beat outputs, forced to zero whenever no beat is offered
  always_comb begin
    trace_valid_o     = 1'b0;
    trace_pc_o        = 32'h0;
    trace_rd_addr_o   = 5'h0;
    trace_rd_wdata_o  = 32'h0;
    trace_slot_o      = {SLOT_W{1'b0}};
    trace_mem_addr_o  = 32'h0;
    trace_mem_rdata_o = 32'h0;
    trace_mem_wdata_o = 32'h0;
    trace_mem_rmask_o = 4'h0;
    trace_mem_wmask_o = 4'h0;
    trace_last_o      = 1'b0;
    if (state_r == EMIT) begin
      trace_valid_o     = 1'b1;
      trace_pc_o        = pc_mem_r[rptr_r];
      trace_rd_addr_o   = rd_addr_mem_r[rptr_r];
      trace_rd_wdata_o  = rd_wdata_mem_r[rptr_r];
      trace_slot_o      = cur_s;
      trace_mem_addr_o  = cur_act_s ? sel_addr_s  : 32'h0;
      trace_mem_rdata_o = cur_act_s ? sel_rdata_s : 32'h0;
      trace_mem_wdata_o = cur_act_s ? sel_wdata_s : 32'h0;
      trace_mem_rmask_o = cur_act_s ? sel_rmask_s : 4'h0;
      trace_mem_wmask_o = cur_act_s ? sel_wmask_s : 4'h0;
      trace_last_o      = last_s;
    end else begin
      trace_valid_o = 1'b0;
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (drop_s) begin
      overflow_o <= 1'b1;
    end else begin
      overflow_o <= overflow_o;
    end
  end

`ifdef CV32E40X_RVFI_TRACE_SEQ_DROPCNT_EN
  logic [15:0] drop_cnt_r;

  // Saturating dropped-record counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_r <= 16'h0000;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`else
  assign drop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cv32e40x_rvfi_trace_sequencer.sv
// Self-checking bench for cv32e40x_rvfi_trace_sequencer: directed steps plus randomized traffic
// compared against a queue-based record/beat model.

module tb_cv32e40x_rvfi_trace_sequencer;

  localparam int DEPTH = 4;
  localparam int NMEM  = cv32e40x_rvfi_pkg::NMEM;
  localparam int SW    = (NMEM > 1) ? $clog2(NMEM) : 1;
`ifdef CV32E40X_RVFI_TRACE_SEQ_DROPCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]        pc;
    logic [4:0]         rd;
    logic [31:0]        wd;
    logic [32*NMEM-1:0] ma;
    logic [32*NMEM-1:0] mr;
    logic [32*NMEM-1:0] mw;
    logic [4*NMEM-1:0]  rm;
    logic [4*NMEM-1:0]  wm;
  } rec_t;

  logic               clk;
  logic               rst_i;
  logic               rvfi_valid;
  logic [31:0]        rvfi_pc_rdata;
  logic [4:0]         rvfi_rd_addr;
  logic [31:0]        rvfi_rd_wdata;
  logic [32*NMEM-1:0] rvfi_mem_addr;
  logic [32*NMEM-1:0] rvfi_mem_rdata;
  logic [32*NMEM-1:0] rvfi_mem_wdata;
  logic [4*NMEM-1:0]  rvfi_mem_rmask;
  logic [4*NMEM-1:0]  rvfi_mem_wmask;
  logic               trace_valid_o;
  logic               trace_ready_i;
  logic [31:0]        trace_pc_o;
  logic [4:0]         trace_rd_addr_o;
  logic [31:0]        trace_rd_wdata_o;
  logic [SW-1:0]      trace_slot_o;
  logic [31:0]        trace_mem_addr_o;
  logic [31:0]        trace_mem_rdata_o;
  logic [31:0]        trace_mem_wdata_o;
  logic [3:0]         trace_mem_rmask_o;
  logic [3:0]         trace_mem_wmask_o;
  logic               trace_last_o;
  logic               overflow_o;
  logic [15:0]        drop_cnt_o;

  cv32e40x_rvfi_trace_sequencer #(.DEPTH(DEPTH), .NMEM(NMEM)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_rd_addr_o(trace_rd_addr_o),
    .trace_rd_wdata_o(trace_rd_wdata_o), .trace_slot_o(trace_slot_o),
    .trace_mem_addr_o(trace_mem_addr_o), .trace_mem_rdata_o(trace_mem_rdata_o),
    .trace_mem_wdata_o(trace_mem_wdata_o), .trace_mem_rmask_o(trace_mem_rmask_o),
    .trace_mem_wmask_o(trace_mem_wmask_o), .trace_last_o(trace_last_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  rec_t q[$];
  int   beat  = 0;
  bit   ovf   = 1'b0;
  int   drops = 0;
  rec_t z;
  rec_t r;

  function automatic bit act(rec_t x, int i);
    return (x.rm[4*i +: 4] | x.wm[4*i +: 4]) != 4'h0;
  endfunction

  // Beats per record: one per active slot, or a single beat when none
  function automatic int nbeats(rec_t x);
    int n = 0;
    for (int i = 0; i < NMEM; i++) if (act(x, i)) n++;
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int nth_slot(rec_t x, int n);
    int k = 0;
    for (int i = 0; i < NMEM; i++) begin
      if (act(x, i)) begin
        if (k == n) return i;
        k++;
      end
    end
    return 0;
  endfunction

  function automatic logic [255:0] exp_vec();
    rec_t          h;
    int            s;
    bit            on;
    logic [SW-1:0] sl;
    logic [31:0]   a, rd_d, wr_d;
    logic [3:0]    rmk, wmk;
    bit            lst;
    if (q.size() == 0) return 256'h0;
    h    = q[0];
    s    = nth_slot(h, beat);
    on   = act(h, s);
    sl   = SW'(s);
    a    = on ? h.ma[32*s +: 32] : 32'h0;
    rd_d = on ? h.mr[32*s +: 32] : 32'h0;
    wr_d = on ? h.mw[32*s +: 32] : 32'h0;
    rmk  = on ? h.rm[4*s +: 4] : 4'h0;
    wmk  = on ? h.wm[4*s +: 4] : 4'h0;
    lst  = (beat == nbeats(h) - 1);
    return 256'({h.pc, h.rd, h.wd, sl, a, rd_d, wr_d, rmk, wmk, lst});
  endfunction

  function automatic rec_t rand_rec();
    rec_t x;
    x.pc = $urandom; x.rd = 5'($urandom); x.wd = $urandom;
    for (int i = 0; i < NMEM; i++) begin
      x.ma[32*i +: 32] = $urandom;
      x.mr[32*i +: 32] = $urandom;
      x.mw[32*i +: 32] = $urandom;
      x.rm[4*i +: 4]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      x.wm[4*i +: 4]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance the model, check just after the edge
  task automatic cyc(input bit v, input rec_t x, input bit rdy, input bit rs);
    bit full;
    @(negedge clk);
    rst_i = rs; rvfi_valid = v; trace_ready_i = rdy;
    rvfi_pc_rdata = x.pc; rvfi_rd_addr = x.rd; rvfi_rd_wdata = x.wd;
    rvfi_mem_addr = x.ma; rvfi_mem_rdata = x.mr; rvfi_mem_wdata = x.mw;
    rvfi_mem_rmask = x.rm; rvfi_mem_wmask = x.wm;
    if (rs) begin
      q.delete(); beat = 0; ovf = 1'b0; drops = 0;
    end else begin
      full = (q.size() == DEPTH);
      if (q.size() != 0 && rdy) begin
        if (beat == nbeats(q[0]) - 1) begin
          void'(q.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
      if (v) begin
        if (full) begin
          ovf = 1'b1;
          if (drops < 65535) drops++;
        end else begin
          q.push_back(x);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("valid", 256'(trace_valid_o), 256'(q.size() != 0));
    chk("beat", 256'({trace_pc_o, trace_rd_addr_o, trace_rd_wdata_o, trace_slot_o,
                      trace_mem_addr_o, trace_mem_rdata_o, trace_mem_wdata_o,
                      trace_mem_rmask_o, trace_mem_wmask_o, trace_last_o}), exp_vec());
    chk("overflow", 256'(overflow_o), 256'(ovf));
    chk("drop_cnt", 256'(drop_cnt_o), CNT_EN ? 256'(drops) : 256'h0);
  endtask

  initial begin
    z = '0;
    rst_i = 1'b1; rvfi_valid = 1'b0; trace_ready_i = 1'b0;
    rvfi_pc_rdata = 32'h0; rvfi_rd_addr = 5'h0; rvfi_rd_wdata = 32'h0;
    rvfi_mem_addr = '0; rvfi_mem_rdata = '0; rvfi_mem_wdata = '0;
    rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;

    cyc(1'b0, z, 1'b1, 1'b1);
    chk("rst_valid", 256'(trace_valid_o), 256'h0);
    cyc(1'b0, z, 1'b1, 1'b0);

    // Single record without memory ops
    r = z; r.pc = 32'h0000_0080;
    cyc(1'b1, r, 1'b1, 1'b0);
    chk("tp1_pc", 256'(trace_pc_o), 256'h80);
    chk("tp1_slot", 256'(trace_slot_o), 256'h0);
    chk("tp1_last", 256'(trace_last_o), 256'h1);
    cyc(1'b0, z, 1'b1, 1'b0);

    // Two active slots
    r = rand_rec(); r.rm = '0; r.wm = '0; r.rm[3:0] = 4'hF; r.wm[7:4] = 4'h3;
    cyc(1'b1, r, 1'b1, 1'b0);
    chk("tp2_b0_slot", 256'(trace_slot_o), 256'h0);
    chk("tp2_b0_rmask", 256'(trace_mem_rmask_o), 256'hF);
    chk("tp2_b0_last", 256'(trace_last_o), 256'h0);
    cyc(1'b0, z, 1'b1, 1'b0);
    chk("tp2_b1_slot", 256'(trace_slot_o), 256'h1);
    chk("tp2_b1_wmask", 256'(trace_mem_wmask_o), 256'h3);
    chk("tp2_b1_last", 256'(trace_last_o), 256'h1);
    cyc(1'b0, z, 1'b1, 1'b0);

    // Only slot 1 active
    r = rand_rec(); r.rm = '0; r.wm = '0; r.wm[7:4] = 4'h1;
    cyc(1'b1, r, 1'b1, 1'b0);
    chk("tp3_slot", 256'(trace_slot_o), 256'h1);
    chk("tp3_last", 256'(trace_last_o), 256'h1);
    cyc(1'b0, z, 1'b1, 1'b0);

    // Overflow under stall, then drain
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, rand_rec(), 1'b0, 1'b0);
    chk("tp4_overflow", 256'(overflow_o), 256'h1);
    chk("tp4_drops", 256'(drop_cnt_o), CNT_EN ? 256'h2 : 256'h0);
    for (int i = 0; i < DEPTH * NMEM + 2; i++) cyc(1'b0, z, 1'b1, 1'b0);
    chk("tp4_drained", 256'(trace_valid_o), 256'h0);

    // Full FIFO with simultaneous pop and push: push is still dropped
    for (int i = 0; i < DEPTH; i++) begin
      r = z; r.pc = $urandom;
      cyc(1'b1, r, 1'b0, 1'b0);
    end
    cyc(1'b1, rand_rec(), 1'b1, 1'b0);
    chk("tp5_drops", 256'(drop_cnt_o), CNT_EN ? 256'h3 : 256'h0);
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, z, 1'b1, 1'b0);

    // Reset in the middle of a two-beat record
    r = rand_rec(); r.rm = '0; r.wm = '0; r.rm[3:0] = 4'h2; r.rm[7:4] = 4'h8;
    cyc(1'b1, r, 1'b1, 1'b0);
    cyc(1'b0, z, 1'b1, 1'b0);
    chk("tp6_mid_slot", 256'(trace_slot_o), 256'h1);
    cyc(1'b0, z, 1'b1, 1'b1);
    chk("tp6_valid", 256'(trace_valid_o), 256'h0);
    chk("tp6_overflow", 256'(overflow_o), 256'h0);
    chk("tp6_drops", 256'(drop_cnt_o), 256'h0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 9) < 6), rand_rec(), ($urandom_range(0, 9) < 5),
          ($urandom_range(0, 249) == 0));
    end
    for (int i = 0; i < DEPTH * NMEM + 2; i++) cyc(1'b0, z, 1'b1, 1'b0);
    chk("final_empty", 256'(trace_valid_o), 256'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
